// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: shares the async FIFO read port round-robin among NUM_REQ consumers, bursts capped at MAX_BURST words.
// Latency: grant 1 cycle after req in IDLE; dvalid 1 cycle after rq, so req->dvalid is 2 cycles minimum.
// Backpressure: rq is held low while the output register is full and its owner's ready is low; dout/dvalid hold.
module fifo_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               rclk,
  input  logic               rrst,
  input  logic               rempty,
  input  logic [DSIZE-1:0]   rdata,
  output logic               rq,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [DSIZE-1:0]   dout,
  output logic [NUM_REQ-1:0] dvalid
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]      BURST_MAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0]      BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [NUM_REQ-1:0] GRANT_ONE  = NUM_REQ'(1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic [CW-1:0] cnt;
  logic          owner_req;
  logic          out_free;
  logic          release_grant;

  // First requester strictly after l, wrapping; returns l itself when only l requests.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IW-1:0]      l);
    logic [IW-1:0] sel;
    logic [IW-1:0] ix;
    logic          found;
    sel   = l;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      ix = IW'((int'(l) + k) % NUM_REQ);
      if (!found && r[ix]) begin
        sel   = ix;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Round-robin candidate for the next grant, only consumed in IDLE.
  always_comb begin
    pick = rr_pick(req, last);
  end

  // State register.
  always_ff @(posedge rclk) begin
    if (rrst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: leave IDLE on any request, leave XFER when the grant is released.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)         state_nxt = XFER;
      XFER:    if (release_grant) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // FSM outputs: read request and grant release, both combinational on the current cycle.
  always_comb begin
    owner_req     = req[owner];
    out_free      = ~|dvalid | (|(dvalid & ready));
    rq            = 1'b0;
    release_grant = 1'b0;
    if (state == XFER) begin
      rq            = owner_req & ~rempty & (cnt < BURST_MAX) & out_free;
      release_grant = (rq & (cnt == BURST_LAST)) | ~owner_req;
    end
  end

  // Grant bookkeeping: owner, one-hot grant, burst count and last winner.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      grant <= '0;
      owner <= '0;
      last  <= IW'(NUM_REQ - 1);
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        grant <= GRANT_ONE << pick;
        owner <= pick;
        cnt   <= '0;
      end
    end else begin
      if (rq) cnt <= cnt + CW'(1);
      if (release_grant) begin
        grant <= '0;
        last  <= owner;
      end
    end
  end

  // Output register: load on rq tagged with the current owner, else drain when the tagged consumer takes it.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      dout   <= '0;
      dvalid <= '0;
    end else if (rq) begin
      dout   <= rdata;
      dvalid <= grant;
    end else if (|(dvalid & ready)) begin
      dvalid <= '0;
    end
  end

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Read-side arbiter for the async FIFO. It shares the FIFO read port (`rq`, `rempty`, `rdata`) among `NUM_REQ` consumers in the read-clock domain. Grants are round-robin and each grant is capped at `MAX_BURST` words. Read data is delivered through a one-entry registered output stage with per-consumer valid/ready handshakes.

## Interface
- `NUM_REQ`, default 4: number of consumers, ≥2.
- `DSIZE`, default 8: FIFO data width.
- `MAX_BURST`, default 4: maximum words per grant, ≥1. The burst counter width is `$clog2(MAX_BURST+1)`.

Ports:
- `rclk` in 1: read-domain clock; the only clock.
- `rrst` in 1: synchronous, active-high reset.
- `rempty` in 1: FIFO empty flag, registered in the FIFO.
- `rdata` in `DSIZE`: FIFO read data, combinational from the memory at the current read address.
- `rq` out 1: FIFO read request; the pointer advances on the next `rclk` edge.
- `req` in `NUM_REQ`: consumer request, level-sensitive.
- `ready` in `NUM_REQ`: consumer accepts output data.
- `grant` out `NUM_REQ`: one-hot current owner, registered; all-zero when idle.
- `dout` out `DSIZE`: output data register.
- `dvalid` out `NUM_REQ`: one-hot valid of the output register, tagged with the owner at load time.

## Operation
- FSM has two states, IDLE and XFER.
- **IDLE:**
  - If `req != 0`, select the first set bit scanning from `last+1` upward, with wrap-around.
  - `grant` becomes that one-hot value at the next edge, `cnt <= 0`, and the state moves to XFER.
  - If `req == 0`, stay in IDLE.
- **XFER, owner g:**
  - `rq = req[g] & ~rempty & (cnt < MAX_BURST) & (~|dvalid | (|(dvalid & ready)))`. The `rq` term is combinational.
  - On `rq`: `dout <= rdata`, `dvalid <= grant`, `cnt <= cnt+1`.
  - Without a new load, `dvalid & ready` nonzero clears `dvalid`.
- **Leaving XFER:** go to IDLE with `last <= g` and `grant <= 0` when either condition holds:
  - `rq` is high and `cnt == MAX_BURST-1` (burst complete), or
  - `req[g] == 0` (`rq` is 0 that cycle).
- **Word ownership:** a word already in the output register stays valid to its owner after the grant ends. `ready` from non-valid consumers is ignored.
- **rempty** in XFER stalls `rq` without ending the grant. The grant is held while `req[g]` stays high and the burst is incomplete.
- **Overflow:** `rq` never asserts while `rempty` is high, so the module cannot over-read.
- **Reset values:**
  - state IDLE
  - `grant` 0, `dvalid` 0, `dout` 0, `cnt` 0
  - `last = NUM_REQ-1`, so consumer 0 wins first
  - `rq` 0
- **Reset mid-operation:** a word in the output register is discarded (the FIFO pointer has already advanced). This is accepted behaviour; the read domain is reset as a whole.

## Timing
- **Grant latency:** with `req` high in IDLE, `grant` is set 1 cycle later.
- **First read:**
  - `rq` can assert in the first XFER cycle.
  - `dvalid` rises the cycle after `rq`.
  - So `req`→`dvalid` is 2 cycles minimum.
- **Throughput:** 1 word/cycle while `ready[g]` is held high, since drain and load happen in the same cycle.
- **Between grants:** 1 IDLE cycle; no read in that cycle.
- **Burst length:** exactly `MAX_BURST` `rq` pulses per grant unless the owner drops `req` earlier.
- **Backpressure:** with `dvalid` set and `ready` low, `rq` is 0 and `dout`/`dvalid` hold.
- **rempty edge:** `rempty` is FIFO-registered. The FIFO's own gating (`rq & ~rempty`) and this block agree every cycle.

## Test plan
- **Single consumer, full burst.** Setup: FIFO preloaded with 0x10..0x17, `MAX_BURST`=4, `req[0]`=1, `ready[0]`=1.
  - `grant`=0001 after 1 cycle; `rq` high for 4 cycles.
  - `dout` = 0x10, 0x11, 0x12, 0x13 on consecutive cycles with `dvalid`=0001.
  - Then 1 IDLE cycle and a regrant to 0 for 0x14..0x17.
- **Round-robin.** Setup: `req`=1111, FIFO holds 16 words, `ready` all 1.
  - Grants 0001→0010→0100→1000, 4 words each.
  - Words 0–3 to consumer 0, words 4–7 to consumer 1, and so on.
  - A fifth arbitration returns to 0001.
- **Backpressure.** Setup: owner 2, `ready[2]`=0 for 3 cycles after the first word.
  - `dvalid`=0100 and `dout` are stable.
  - `rq`=0 during the stall.
  - Streaming resumes the cycle `ready[2]` rises, with no word lost or duplicated.
- **Empty stall.** Setup: FIFO holds 1 word, owner 1, `MAX_BURST`=4.
  - One `rq`, then `rq`=0 while `rempty`=1 with `grant` held.
  - Push 2 words; they arrive as `cnt` goes 2, 3; the grant persists until the fourth word or `req` drops.
- **Early release and reset.**
  - Owner 0 drops `req` after 2 words → IDLE next cycle, `req[1]` wins. The pending word is still delivered on `dvalid`=0001.
  - Asserting `rrst` mid-burst → next cycle `grant`=0, `dvalid`=0, `rq`=0. After release, consumer 0 wins first.
